median_window_gen: RTL and testbench

//  Producer side of the 72-bit median-filter window interface. Accepts a raster pixel stream
//  (one 8-bit pixel per accepted beat) and buffers the last two image lines. Emits each complete
//  3x3 neighbourhood as one 72-bit word with a valid/ready handshake for the downstream median

---
 rtl/median_window_gen.sv | 95 +++++++++
 tb/tb_median_window_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/median_window_gen.sv
// 3x3 window generator for a raster pixel stream. Two line buffers and three column shift registers
// produce one registered 9*PIX_W window per interior pixel, handed off with a valid/ready handshake.
module median_window_gen #(
  parameter int IMG_W = 8,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               sof,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  input  logic               win_ready
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int SW = 3 * PIX_W;

  logic [CW-1:0]      r_col;
  logic [1:0]         r_row;
  logic [PIX_W-1:0]   r_lb1 [IMG_W];
  logic [PIX_W-1:0]   r_lb2 [IMG_W];
  logic [SW-1:0]      r_sr0, r_sr1, r_sr2;
  logic [9*PIX_W-1:0] r_win;
  logic               r_win_valid;

  logic               w_acc;
  logic [CW-1:0]      w_eff_col;
  logic [1:0]         w_eff_row;
  logic [PIX_W-1:0]   w_lb1_rd, w_lb2_rd;
  logic [SW-1:0]      w_sr0_nx, w_sr1_nx, w_sr2_nx;
  logic               w_last_col;
  logic               w_complete;

  assign pix_ready  = ~r_win_valid | win_ready;
  assign w_acc      = pix_valid & pix_ready;
  assign w_eff_col  = sof ? '0 : r_col;
  assign w_eff_row  = sof ? 2'd0 : r_row;
  assign w_lb1_rd   = r_lb1[w_eff_col];
  assign w_lb2_rd   = r_lb2[w_eff_col];

  // Newest pixel enters the top slot so the low byte of each row is the oldest column.
  assign w_sr0_nx   = {w_lb2_rd, r_sr0[SW-1:PIX_W]};
  assign w_sr1_nx   = {w_lb1_rd, r_sr1[SW-1:PIX_W]};
  assign w_sr2_nx   = {pix_in,   r_sr2[SW-1:PIX_W]};

  assign w_last_col = (w_eff_col == CW'(IMG_W - 1));
  assign w_complete = w_acc && (w_eff_row == 2'd2) && (w_eff_col >= CW'(2));

  assign win_out    = r_win;
  assign win_valid  = r_win_valid;

  // Line RAMs are deliberately not reset; rows 0/1 overwrite them before any window reads them.
  always_ff @(posedge clk) begin
    if (w_acc && !rst) begin
      r_lb2[w_eff_col] <= w_lb1_rd;
      r_lb1[w_eff_col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= 2'd0;
      r_sr0       <= '0;
      r_sr1       <= '0;
      r_sr2       <= '0;
      r_win       <= '0;
      r_win_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_sr0 <= w_sr0_nx;
        r_sr1 <= w_sr1_nx;
        r_sr2 <= w_sr2_nx;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= (w_eff_row == 2'd2) ? 2'd2 : w_eff_row + 2'd1;
        end else begin
          r_col <= w_eff_col + CW'(1);
          r_row <= w_eff_row;
        end
      end
      // A completion in the same cycle as a consume simply replaces the window.
      if (w_complete) begin
        r_win       <= {w_sr2_nx, w_sr1_nx, w_sr0_nx};
        r_win_valid <= 1'b1;
      end else if (r_win_valid && win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen: IMG_W=4 instance for streaming, backpressure, sof and
// reset scenarios, plus an IMG_W=3 instance for the border-gating case.
module tb_median_window_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix_in;
  logic        pix_valid, sof, pix_ready;
  logic [71:0] win_out;
  logic        win_valid, win_ready;

  logic [7:0]  pix3;
  logic        valid3, sof3, ready3;
  logic [71:0] wout3;
  logic        wvalid3;
  logic        wready3;

  always #5 clk = ~clk;

  median_window_gen #(.IMG_W(4), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .pix_ready(pix_ready), .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready)
  );

  median_window_gen #(.IMG_W(3), .PIX_W(8)) dut3 (
    .clk(clk), .rst(rst), .pix_in(pix3), .pix_valid(valid3), .sof(sof3),
    .pix_ready(ready3), .win_out(wout3), .win_valid(wvalid3), .win_ready(wready3)
  );

  int total = 0;
  int bad   = 0;
  int n_win = 0;
  int n3    = 0;
  logic [71:0] exp_q[$];

  // Hand-computed windows of a 4x4 frame holding pixels 1..16 in raster order.
  logic [71:0] W11 = 72'h0B0A09070605030201;
  logic [71:0] W12 = 72'h0C0B0A080706040302;
  logic [71:0] W15 = 72'h0F0E0D0B0A0907_0605;
  logic [71:0] W16 = 72'h100F0E0C0B0A080706;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    exp_q.push_back(W11);
    exp_q.push_back(W12);
    exp_q.push_back(W15);
    exp_q.push_back(W16);
  endtask

  // Scoreboard monitor: every consumed window must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && win_valid && win_ready) begin
      n_win++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_window: got %h expected none", win_out);
      end else begin
        check("window", win_out, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && wvalid3) begin
      n3++;
      check("w3_bytes", wout3, {9{8'hFF}});
    end
  end

  task automatic send(input int p, input logic s, inout int stalls);
    int n;
    pix_in    = 8'(p);
    sof       = s;
    pix_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pix_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    stalls += n;
    if (!pix_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: pixel %0d pix_ready=%b expected 1", p, pix_ready);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic frame(input int first, input int last, input logic first_sof, inout int stalls);
    for (int p = first; p <= last; p++) send(p, first_sof && (p == first), stalls);
  endtask

  task automatic drain(input string name, input int exp_n);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_queue_empty"}, 72'(exp_q.size()), 72'd0);
    check({name, "_win_count"}, 72'(n_win), 72'(exp_n));
  endtask

  initial begin
    int st;
    rst = 1'b1; pix_in = '0; pix_valid = 1'b0; sof = 1'b0; win_ready = 1'b1;
    pix3 = '0; valid3 = 1'b0; sof3 = 1'b0; wready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_win_valid", 72'(win_valid), 72'd0);
    check("rst_win_out", win_out, 72'd0);
    check("rst_pix_ready", 72'(pix_ready), 72'd1);

    // Streaming frame: first-window latency and back-to-back windows within a line.
    n_win = 0; st = 0;
    push_frame();
    frame(1, 10, 1'b1, st);
    check("t1_no_win_before_11", 72'(win_valid), 72'd0);
    send(11, 1'b0, st);
    check("t1_valid_after_11", 72'(win_valid), 72'd1);
    check("t1_first_win", win_out, W11);
    send(12, 1'b0, st);
    check("t3_valid_after_12", 72'(win_valid), 72'd1);
    check("t3_win_12", win_out, W12);
    frame(13, 16, 1'b0, st);
    check("t3_no_stalls", 72'(st), 72'd0);
    drain("t1", 4);

    // Backpressure on the first window.
    n_win = 0; st = 0;
    push_frame();
    frame(1, 10, 1'b1, st);
    win_ready = 1'b0;
    send(11, 1'b0, st);
    pix_in = 8'd12; pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_pix_ready_held", 72'(pix_ready), 72'd0);
      check("t2_win_stable", win_out, W11);
    end
    @(posedge clk);
    #1;
    win_ready = 1'b1;
    send(12, 1'b0, st);
    check("t2_next_win", win_out, W12);
    frame(13, 16, 1'b0, st);
    drain("t2", 4);

    // sof mid-frame after pixel 7.
    n_win = 0; st = 0;
    frame(1, 7, 1'b1, st);
    push_frame();
    frame(1, 16, 1'b1, st);
    drain("t4", 4);

    // Reset while a window is held; restream without sof.
    n_win = 0; st = 0;
    frame(1, 10, 1'b1, st);
    win_ready = 1'b0;
    send(11, 1'b0, st);
    check("t5_held_win", win_out, W11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_valid_cleared", 72'(win_valid), 72'd0);
    check("t5_out_cleared", win_out, 72'd0);
    check("t5_pix_ready", 72'(pix_ready), 72'd1);
    win_ready = 1'b1;
    push_frame();
    frame(1, 16, 1'b0, st);
    drain("t5", 4);

    // Border gating on a 3x3 frame of 0xFF.
    n3 = 0;
    for (int i = 0; i < 9; i++) begin
      pix3 = 8'hFF; valid3 = 1'b1; sof3 = (i == 0);
      @(posedge clk);
      #1;
    end
    valid3 = 1'b0; sof3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_window_count", 72'(n3), 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
